// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite register bank. AW/W are captured in any order and commit together, giving bvalid one cycle later; AR gives rvalid one cycle later.
// Each path holds its response until the initiator is ready, and the readys stay low while a response is outstanding.
module axi_lite_reg_responder #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [31:0]            araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic [NUM_REGS*32-1:0] regs_q
);

  localparam int          IW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] RANGE_BYTES = 32'(NUM_REGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  logic [0:0]  wState;
  logic [0:0]  rState;
  logic        awHeld;
  logic        wHeld;
  logic [31:0] awAddrQ;
  logic [31:0] wDataQ;
  logic [3:0]  wStrbQ;
  logic [31:0] regs [NUM_REGS];

  logic        awHit;
  logic        wHit;
  logic        arHit;
  logic        commit;
  logic [31:0] curAwAddr;
  logic [31:0] curWData;
  logic [3:0]  curWStrb;
  logic [31:0] awOff;
  logic [31:0] arOff;
  logic        awOk;
  logic        arOk;
  logic [IW-1:0] awIdx;
  logic [IW-1:0] arIdx;

  assign awready = !rst && (wState == W_IDLE) && !awHeld;
  assign wready  = !rst && (wState == W_IDLE) && !wHeld;
  assign arready = !rst && (rState == R_IDLE);
  assign bvalid  = (wState == W_RESP);
  assign rvalid  = (rState == R_RESP);

  assign awHit = awvalid && awready;
  assign wHit  = wvalid && wready;
  assign arHit = arvalid && arready;

  // A channel captured earlier takes priority over whatever is on the bus now.
  assign curAwAddr = awHeld ? awAddrQ : awaddr;
  assign curWData  = wHeld ? wDataQ : wdata;
  assign curWStrb  = wHeld ? wStrbQ : wstrb;
  assign commit    = (wState == W_IDLE) && (awHeld || awHit) && (wHeld || wHit);

  // Offset wraps below the base, so a plain unsigned byte-range compare is enough.
  assign awOff = curAwAddr - BASE_ADDR;
  assign arOff = araddr - BASE_ADDR;
  assign awOk  = awOff < RANGE_BYTES;
  assign arOk  = arOff < RANGE_BYTES;
  assign awIdx = awOff[IW+1:2];
  assign arIdx = arOff[IW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      wState  <= W_IDLE;
      awHeld  <= 1'b0;
      wHeld   <= 1'b0;
      awAddrQ <= '0;
      wDataQ  <= '0;
      wStrbQ  <= '0;
      bresp   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (commit) begin
        wState <= W_RESP;
        awHeld <= 1'b0;
        wHeld  <= 1'b0;
        bresp  <= awOk ? RESP_OKAY : RESP_SLVERR;
        for (int b = 0; b < 4; b++) begin
          if (awOk && curWStrb[b]) begin
            regs[awIdx][8*b +: 8] <= curWData[8*b +: 8];
          end
        end
      end else begin
        if (awHit) begin
          awHeld  <= 1'b1;
          awAddrQ <= awaddr;
        end
        if (wHit) begin
          wHeld  <= 1'b1;
          wDataQ <= wdata;
          wStrbQ <= wstrb;
        end
      end
      if ((wState == W_RESP) && bready) begin
        wState <= W_IDLE;
      end
    end
  end

  // Reads sample the bank before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rState <= R_IDLE;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (rState == R_IDLE) begin
      if (arHit) begin
        rState <= R_RESP;
        rdata  <= arOk ? regs[arIdx] : 32'h0;
        rresp  <= arOk ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (rready) begin
      rState <= R_IDLE;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : gen_flat
    assign regs_q[32*i +: 32] = regs[i];
  end

endmodule
